// File: rtl/sparse_writer_pkg.sv
// sparse_writer_pkg
//   Shared definitions for the sparse IFM chunk writer.
//   - cyc_num():   beats per chunk buffer (MEM_SIZE / BUS_SIZE).
//   - cnt_width(): width of the beat counter inside one chunk.
//   - wr_state_e:  writer FSM states.
package sparse_writer_pkg;

  localparam int DEF_BUS_SIZE = 32;
  localparam int DEF_MEM_SIZE = 256;

  function automatic int cyc_num(input int mem_size, input int bus_size);
    return mem_size / bus_size;
  endfunction

  // A one-beat chunk still needs a 1-bit counter so the port is never zero-width.
  function automatic int cnt_width(input int cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

  typedef enum logic [1:0] {
    WAIT_BUF = 2'd0,
    FILL     = 2'd1,
    PAD      = 2'd2
  } wr_state_e;

endpackage

// File: rtl/sparse_chunk_writer_compactor.sv
// sparse_beat_compactor
//   Purely combinational compaction of one dense beat.
//   Ports:
//     dense_data  in   BUS_SIZE bytes, byte 0 in the low bits.
//     sparsemap   out  bit i set when dense byte i is nonzero.
//     packed_data out  nonzero bytes left-packed in ascending source order,
//                      unused slots zero.
//     popcount    out  number of nonzero bytes in the beat.
module sparse_beat_compactor #(
  parameter int BUS_SIZE = 32
) (
  input  logic [BUS_SIZE*8-1:0]    dense_data,
  output logic [BUS_SIZE-1:0]      sparsemap,
  output logic [BUS_SIZE*8-1:0]    packed_data,
  output logic [$clog2(BUS_SIZE):0] popcount
);

  localparam int POP_W = $clog2(BUS_SIZE) + 1;

  // prefix[i] = number of nonzero bytes strictly below byte i, i.e. the
  // packed slot that byte i lands in when it is itself nonzero.
  logic [POP_W-1:0] prefix [BUS_SIZE];

  genvar gi;
  generate
    for (gi = 0; gi < BUS_SIZE; gi++) begin : g_flag
      assign sparsemap[gi] = |dense_data[gi*8 +: 8];
    end
  endgenerate

  always_comb begin : prefix_sum
    logic [POP_W-1:0] run;
    run = '0;
    for (int i = 0; i < BUS_SIZE; i++) begin
      prefix[i] = run;
      run       = run + POP_W'(sparsemap[i]);
    end
    popcount = run;
  end

  // Slot gi can only be filled from source bytes at index >= gi, and at most
  // one nonzero byte has a given prefix count, so a priority-free select works.
  generate
    for (gi = 0; gi < BUS_SIZE; gi++) begin : g_slot
      logic [7:0] slot;
      always_comb begin
        slot = '0;
        for (int i = gi; i < BUS_SIZE; i++) begin
          if (sparsemap[i] && (prefix[i] == POP_W'(gi))) begin
            slot = dense_data[i*8 +: 8];
          end
        end
      end
      assign packed_data[gi*8 +: 8] = slot;
    end
  endgenerate

endmodule

// File: rtl/sparse_chunk_writer.sv
// sparse_chunk_writer
//   Producer side of the compressed-IFM write port. Compacts dense beats and
//   streams one chunk of CYC_NUM beats into each of two ping-pong buffers,
//   never writing a buffer the consumer still owns.
//   Ports:
//     clk_i, rst_i            clock, asynchronous active-high reset
//     dense_valid_i/ready_o   beat handshake from the fetch path
//     dense_data_i            dense beat, byte 0 in the low bits
//     dense_last_i            early end of chunk (remaining beats are padded)
//     sparsemap_o             nonzero flags of the written beat
//     nonzero_data_o          left-packed nonzero bytes of the written beat
//     wr_valid_o              one-cycle write strobe per beat
//     wr_count_o / wr_sel_o   beat index within chunk / target buffer
//     buf_release_i/_sel_i    consumer frees a buffer
//     buf_full_o              occupancy flag per buffer
//     chunk_done_o            pulse with the final beat of a chunk
//     nnz_count_o             nonzero total of the chunk, held between chunks
module sparse_chunk_writer
  import sparse_writer_pkg::*;
#(
  parameter int BUS_SIZE = DEF_BUS_SIZE,
  parameter int MEM_SIZE = DEF_MEM_SIZE
) (
  input  logic                                               clk_i,
  input  logic                                               rst_i,
  input  logic                                               dense_valid_i,
  output logic                                               dense_ready_o,
  input  logic [BUS_SIZE*8-1:0]                              dense_data_i,
  input  logic                                               dense_last_i,
  output logic [BUS_SIZE-1:0]                                sparsemap_o,
  output logic [BUS_SIZE*8-1:0]                              nonzero_data_o,
  output logic                                               wr_valid_o,
  output logic [cnt_width(cyc_num(MEM_SIZE, BUS_SIZE))-1:0]  wr_count_o,
  output logic                                               wr_sel_o,
  input  logic                                               buf_release_i,
  input  logic                                               buf_release_sel_i,
  output logic [1:0]                                         buf_full_o,
  output logic                                               chunk_done_o,
  output logic [$clog2(MEM_SIZE):0]                          nnz_count_o
);

  localparam int CYC_NUM = cyc_num(MEM_SIZE, BUS_SIZE);
  localparam int CNT_W   = cnt_width(CYC_NUM);
  localparam int NNZ_W   = $clog2(MEM_SIZE) + 1;
  localparam int POP_W   = $clog2(BUS_SIZE) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYC_NUM - 1);

  wr_state_e state_reg, state_next;

  logic                  cur_sel_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [1:0]            buf_full_reg, buf_full_next;
  logic [NNZ_W-1:0]      nnz_acc_reg, nnz_acc_next;
  logic [BUS_SIZE-1:0]   sparsemap_reg;
  logic [BUS_SIZE*8-1:0] data_reg;
  logic                  wr_valid_reg;
  logic [CNT_W-1:0]      wr_count_reg;
  logic                  wr_sel_reg;
  logic                  chunk_done_reg;
  logic [NNZ_W-1:0]      nnz_count_reg;

  logic                  ready;
  logic                  accept;
  logic                  emit;
  logic                  emit_pad;
  logic                  chunk_end;
  logic [1:0]            rel_mask;
  logic [1:0]            set_mask;
  logic [1:0]            full_after_rel;

  logic [BUS_SIZE-1:0]   beat_map;
  logic [BUS_SIZE*8-1:0] beat_packed;
  logic [POP_W-1:0]      beat_pop;

  sparse_beat_compactor #(
    .BUS_SIZE (BUS_SIZE)
  ) u_compactor (
    .dense_data  (dense_data_i),
    .sparsemap   (beat_map),
    .packed_data (beat_packed),
    .popcount    (beat_pop)
  );

  // Occupancy: a release clears first, a chunk end sets afterwards, so a
  // simultaneous set and release of the same buffer leaves it full.
  always_comb begin
    rel_mask[0]    = buf_release_i & ~buf_release_sel_i;
    rel_mask[1]    = buf_release_i &  buf_release_sel_i;
    set_mask[0]    = chunk_end & ~cur_sel_reg;
    set_mask[1]    = chunk_end &  cur_sel_reg;
    full_after_rel = buf_full_reg & ~rel_mask;
    buf_full_next  = full_after_rel | set_mask;
  end

  // Next-state and control decode.
  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    accept     = 1'b0;
    emit       = 1'b0;
    emit_pad   = 1'b0;
    chunk_end  = 1'b0;
    case (state_reg)
      WAIT_BUF: begin
        // Looking at the post-release flags lets a release at t open the
        // port at t+1.
        if (!full_after_rel[cur_sel_reg]) begin
          state_next = FILL;
        end
      end
      FILL: begin
        ready = 1'b1;
        if (dense_valid_i) begin
          accept = 1'b1;
          emit   = 1'b1;
          if (cnt_reg == LAST_CNT) begin
            chunk_end  = 1'b1;
            state_next = WAIT_BUF;
          end else if (dense_last_i) begin
            state_next = PAD;
          end
        end
      end
      PAD: begin
        emit     = 1'b1;
        emit_pad = 1'b1;
        if (cnt_reg == LAST_CNT) begin
          chunk_end  = 1'b1;
          state_next = WAIT_BUF;
        end
      end
      default: begin
        state_next = WAIT_BUF;
      end
    endcase
  end

  always_comb begin
    nnz_acc_next = nnz_acc_reg + (accept ? NNZ_W'(beat_pop) : '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= WAIT_BUF;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_sel_reg    <= 1'b0;
      cnt_reg        <= '0;
      buf_full_reg   <= '0;
      nnz_acc_reg    <= '0;
      sparsemap_reg  <= '0;
      data_reg       <= '0;
      wr_valid_reg   <= 1'b0;
      wr_count_reg   <= '0;
      wr_sel_reg     <= 1'b0;
      chunk_done_reg <= 1'b0;
      nnz_count_reg  <= '0;
    end else begin
      buf_full_reg   <= buf_full_next;
      wr_valid_reg   <= emit;
      chunk_done_reg <= chunk_end;

      // Data outputs only move on a write so they hold between strobes.
      if (emit) begin
        wr_count_reg  <= cnt_reg;
        wr_sel_reg    <= cur_sel_reg;
        sparsemap_reg <= emit_pad ? '0 : beat_map;
        data_reg      <= emit_pad ? '0 : beat_packed;
        cnt_reg       <= chunk_end ? '0 : cnt_reg + CNT_W'(1);
      end

      if (chunk_end) begin
        cur_sel_reg   <= ~cur_sel_reg;
        nnz_count_reg <= nnz_acc_next;
        nnz_acc_reg   <= '0;
      end else if (accept) begin
        nnz_acc_reg   <= nnz_acc_next;
      end
    end
  end

  assign dense_ready_o  = ready;
  assign sparsemap_o    = sparsemap_reg;
  assign nonzero_data_o = data_reg;
  assign wr_valid_o     = wr_valid_reg;
  assign wr_count_o     = wr_count_reg;
  assign wr_sel_o       = wr_sel_reg;
  assign buf_full_o     = buf_full_reg;
  assign chunk_done_o   = chunk_done_reg;
  assign nnz_count_o    = nnz_count_reg;

endmodule

// File: tb/tb_sparse_chunk_writer.sv
// Self-checking bench for sparse_chunk_writer: a transaction-level model
// predicts every output each cycle, plus literal expectations from hand
// calculations for the directed scenarios.
module tb_sparse_chunk_writer;

  localparam int BUS = 32;
  localparam int MEM = 256;
  localparam int CYC = MEM / BUS;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             dense_valid_i = 1'b0;
  logic             dense_ready_o;
  logic [BUS*8-1:0] dense_data_i = '0;
  logic             dense_last_i = 1'b0;
  logic [BUS-1:0]   sparsemap_o;
  logic [BUS*8-1:0] nonzero_data_o;
  logic             wr_valid_o;
  logic [2:0]       wr_count_o;
  logic             wr_sel_o;
  logic             buf_release_i = 1'b0;
  logic             buf_release_sel_i = 1'b0;
  logic [1:0]       buf_full_o;
  logic             chunk_done_o;
  logic [8:0]       nnz_count_o;

  always #5 clk_i = ~clk_i;

  sparse_chunk_writer #(.BUS_SIZE(BUS), .MEM_SIZE(MEM)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .dense_valid_i     (dense_valid_i),
    .dense_ready_o     (dense_ready_o),
    .dense_data_i      (dense_data_i),
    .dense_last_i      (dense_last_i),
    .sparsemap_o       (sparsemap_o),
    .nonzero_data_o    (nonzero_data_o),
    .wr_valid_o        (wr_valid_o),
    .wr_count_o        (wr_count_o),
    .wr_sel_o          (wr_sel_o),
    .buf_release_i     (buf_release_i),
    .buf_release_sel_i (buf_release_sel_i),
    .buf_full_o        (buf_full_o),
    .chunk_done_o      (chunk_done_o),
    .nnz_count_o       (nnz_count_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit auto_rel = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the chunk as "beats written so far", "pad beats owed" and buffer
  // ownership; the packed vector is built from a queue of nonzero bytes.
  logic [255:0] m_data = '0;
  logic [31:0]  m_smap = '0;
  bit           m_valid = 0, m_done = 0, m_ready = 0, m_pad = 0, m_end = 0;
  int           m_cnt = 0, m_osel = 0, m_nnz = 0, m_sel = 0, m_idx = 0, m_acc = 0;
  bit [1:0]     m_full = 0, m_fn = 0;
  logic [7:0]   m_q[$];

  task automatic model_step();
    if (rst_i) begin
      m_data = '0; m_smap = '0; m_valid = 0; m_done = 0; m_ready = 0; m_pad = 0;
      m_cnt = 0; m_osel = 0; m_nnz = 0; m_sel = 0; m_idx = 0; m_acc = 0; m_full = 0;
      return;
    end
    m_valid = 0; m_done = 0; m_end = 0;
    if (m_pad) begin
      m_smap = '0; m_data = '0; m_valid = 1; m_cnt = m_idx; m_osel = m_sel;
      m_idx++;
      if (m_idx == CYC) m_end = 1;
    end else if (m_ready && dense_valid_i) begin
      m_q.delete();
      for (int i = 0; i < BUS; i++) begin
        m_smap[i] = (dense_data_i[i*8 +: 8] != 8'd0);
        if (m_smap[i]) m_q.push_back(dense_data_i[i*8 +: 8]);
      end
      m_data = '0;
      foreach (m_q[k]) m_data[k*8 +: 8] = m_q[k];
      m_acc += m_q.size();
      m_valid = 1; m_cnt = m_idx; m_osel = m_sel;
      m_idx++;
      if (m_idx == CYC) m_end = 1;
      else if (dense_last_i) begin m_pad = 1; m_ready = 0; end
    end
    m_fn = m_full;
    if (buf_release_i) m_fn[buf_release_sel_i] = 1'b0;
    if (m_end) begin
      m_fn[m_sel] = 1'b1;
      m_done = 1; m_nnz = m_acc; m_acc = 0; m_idx = 0;
      m_sel = 1 - m_sel; m_pad = 0; m_ready = 0;
    end else if (!m_ready && !m_pad) begin
      m_ready = !m_fn[m_sel];
    end
    m_full = m_fn;
  endtask

  initial forever begin
    @(posedge clk_i or posedge rst_i);
    model_step();
  end

  // One compare process: every output against the model on every cycle.
  initial forever begin
    @(negedge clk_i);
    check("ready",     256'(dense_ready_o),  256'(m_ready));
    check("wr_valid",  256'(wr_valid_o),     256'(m_valid));
    check("wr_count",  256'(wr_count_o),     256'(m_cnt));
    check("wr_sel",    256'(wr_sel_o),       256'(m_osel));
    check("sparsemap", 256'(sparsemap_o),    256'(m_smap));
    check("nz_data",   nonzero_data_o,       m_data);
    check("buf_full",  256'(buf_full_o),     256'(m_full));
    check("done",      256'(chunk_done_o),   256'(m_done));
    check("nnz",       256'(nnz_count_o),    256'(m_nnz));
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [255:0] rand_beat(input int k);
    logic [255:0] b;
    int placed;
    int p;
    b = '0;
    placed = 0;
    while (placed < k) begin
      p = $urandom_range(0, BUS - 1);
      if (b[p*8 +: 8] == 8'd0) begin
        b[p*8 +: 8] = 8'($urandom_range(1, 255));
        placed++;
      end
    end
    return b;
  endfunction

  // Called just after a falling edge; returns one falling edge after the
  // rising edge that accepted the beat, so the beat's outputs are visible.
  task automatic send_beat(input logic [255:0] d, input logic l);
    int w;
    w = 0;
    dense_valid_i = 1'b1;
    dense_data_i  = d;
    dense_last_i  = l;
    while (!dense_ready_o && w < 200) begin
      if (auto_rel) begin
        buf_release_i     = 1'($urandom_range(0, 1));
        buf_release_sel_i = 1'($urandom_range(0, 1));
      end
      @(negedge clk_i);
      w++;
    end
    if (w >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout @%0t: got ready=0 for %0d cycles, want 1", $time, w);
    end
    @(negedge clk_i);
    dense_valid_i = 1'b0;
    dense_last_i  = 1'b0;
    if (auto_rel) buf_release_i = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (wr_valid_o && chunk_done_o) begin ok = 1; break; end
      @(negedge clk_i);
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout @%0t: got no chunk_done, want one within 40 cycles", $time);
    end
  endtask

  task automatic pulse_release(input logic s);
    buf_release_i     = 1'b1;
    buf_release_sel_i = s;
    @(negedge clk_i);
    buf_release_i     = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [255:0] b;

    repeat (3) @(negedge clk_i);
    check("lit_rst_full",  256'(buf_full_o),  256'(2'b00));
    check("lit_rst_valid", 256'(wr_valid_o),  256'(1'b0));
    check("lit_rst_ready", 256'(dense_ready_o), 256'(1'b0));
    rst_i = 1'b0;
    @(negedge clk_i);

    // Chunk A: all-nonzero beat, then a two-byte beat ending the chunk early.
    b = '0;
    for (int i = 0; i < BUS; i++) b[i*8 +: 8] = 8'(i + 1);
    send_beat(b, 1'b0);
    check("lit_a0_valid", 256'(wr_valid_o),  256'(1'b1));
    check("lit_a0_count", 256'(wr_count_o),  256'(3'd0));
    check("lit_a0_sel",   256'(wr_sel_o),    256'(1'b0));
    check("lit_a0_smap",  256'(sparsemap_o), 256'(32'hFFFF_FFFF));
    check("lit_a0_data",  nonzero_data_o,    b);
    b = '0;
    b[3*8 +: 8]  = 8'hAA;
    b[17*8 +: 8] = 8'h55;
    send_beat(b, 1'b1);
    check("lit_a1_smap",  256'(sparsemap_o), 256'(32'h0002_0008));
    check("lit_a1_data",  nonzero_data_o,    256'h55AA);
    check("lit_a1_count", 256'(wr_count_o),  256'(3'd1));
    wait_done();
    check("lit_a_nnz",    256'(nnz_count_o), 256'(9'd34));
    check("lit_a_count",  256'(wr_count_o),  256'(3'd7));
    check("lit_a_full",   256'(buf_full_o),  256'(2'b01));
    pulse_release(1'b0);

    // Chunk B: random full chunk into buffer 1.
    for (int k = 0; k < CYC; k++) send_beat(rand_beat($urandom_range(0, BUS)), 1'b0);
    wait_done();
    pulse_release(1'b1);

    // Chunk C: eight back-to-back beats of four nonzeros each into buffer 0.
    for (int k = 0; k < CYC; k++) begin
      send_beat(rand_beat(4), 1'b0);
      check("lit_c_count", 256'(wr_count_o), 256'(k));
    end
    check("lit_c_done", 256'(chunk_done_o), 256'(1'b1));
    check("lit_c_nnz",  256'(nnz_count_o),  256'(9'd32));
    check("lit_c_full", 256'(buf_full_o),   256'(2'b01));

    // Chunk D lands in buffer 1, leaving both buffers full.
    send_beat(rand_beat(7), 1'b0);
    check("lit_d_sel", 256'(wr_sel_o), 256'(1'b1));
    for (int k = 1; k < CYC; k++) send_beat(rand_beat(7), 1'b0);
    wait_done();
    check("lit_d_full", 256'(buf_full_o), 256'(2'b11));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      check("lit_stall_ready", 256'(dense_ready_o), 256'(1'b0));
    end
    pulse_release(1'b0);
    check("lit_rel_ready", 256'(dense_ready_o), 256'(1'b1));

    // Chunk E: early last on beat 2, then five pad beats.
    send_beat(rand_beat(2), 1'b0);
    check("lit_e_sel", 256'(wr_sel_o), 256'(1'b0));
    send_beat(rand_beat(2), 1'b0);
    send_beat(rand_beat(2), 1'b1);
    check("lit_e_ready", 256'(dense_ready_o), 256'(1'b0));
    for (int k = 3; k < CYC; k++) begin
      @(negedge clk_i);
      check("lit_pad_valid", 256'(wr_valid_o),  256'(1'b1));
      check("lit_pad_count", 256'(wr_count_o),  256'(k));
      check("lit_pad_smap",  256'(sparsemap_o), 256'(32'd0));
    end
    check("lit_e_done", 256'(chunk_done_o), 256'(1'b1));
    check("lit_e_nnz",  256'(nnz_count_o),  256'(9'd6));
    pulse_release(1'b0);
    pulse_release(1'b1);

    // Reset in the middle of a chunk.
    for (int k = 0; k < 4; k++) send_beat(rand_beat(5), 1'b0);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("lit_mrst_full",  256'(buf_full_o),  256'(2'b00));
    check("lit_mrst_valid", 256'(wr_valid_o),  256'(1'b0));
    check("lit_mrst_smap",  256'(sparsemap_o), 256'(32'd0));
    check("lit_mrst_nnz",   256'(nnz_count_o), 256'(9'd0));
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    send_beat(rand_beat(3), 1'b0);
    check("lit_post_count", 256'(wr_count_o), 256'(3'd0));
    check("lit_post_sel",   256'(wr_sel_o),   256'(1'b0));

    // Random traffic with a random consumer.
    auto_rel = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        buf_release_i     = 1'($urandom_range(0, 3) == 0);
        buf_release_sel_i = 1'($urandom_range(0, 1));
        @(negedge clk_i);
      end
      buf_release_i     = 1'($urandom_range(0, 3) == 0);
      buf_release_sel_i = 1'($urandom_range(0, 1));
      send_beat(rand_beat($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, BUS)),
                1'($urandom_range(0, 7) == 0));
    end
    auto_rel = 1'b0;
    buf_release_i = 1'b0;
    repeat (20) @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
